// File: rtl/mm_initiator.sv
// ----------------------------------------------------------------------------
// mm_initiator
//
// Purpose:
//   Single-outstanding memory-mapped bus initiator. It accepts one read or
//   write command at a time and issues a one-cycle rd_req or wr_req pulse on
//   the bus side. A read then waits for data_valid from the responder, up to
//   TIMEOUT_CYCLES cycles, and returns the read data or an error response.
//   Timed-out reads are tallied in a saturating 8-bit error counter.
//
// Configuration macro:
//   MM_INITIATOR_WRITE_ACK_EN
//     - defined   : each write also produces a response (rsp_data=0,
//                   rsp_err=0) that must be consumed before the next command.
//     - undefined : writes return straight to IDLE and produce no response.
//
// Parameters:
//   TIMEOUT_CYCLES  Maximum READ_WAIT cycles before a read fails (1..255).
//
// Ports:
//   clk         in   1   system clock, all state on posedge
//   reset       in   1   asynchronous, active-high reset
//   cmd_valid   in   1   command offered
//   cmd_ready   out  1   high only in IDLE; accept on valid && ready
//   cmd_write   in   1   1 = write, 0 = read
//   cmd_addr    in   32  command address
//   cmd_wdata   in   32  command write data
//   rsp_valid   out  1   response available (held until rsp_ready)
//   rsp_ready   in   1   response consumed on valid && ready
//   rsp_data    out  32  read data; 0 on error or write ack
//   rsp_err     out  1   1 = read timed out
//   rd_req      out  1   bus read request pulse
//   rd_addr     out  32  bus read address (holds last latched address)
//   rd_data     in   32  bus read data
//   data_valid  in   1   rd_data qualifier, honoured only in READ_WAIT
//   wr_req      out  1   bus write request pulse
//   wr_addr     out  32  bus write address (holds last latched address)
//   wr_data     out  32  bus write data (holds last latched data)
//   err_count   out  8   saturating count of timed-out reads
// ----------------------------------------------------------------------------
module mm_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    input  logic        data_valid,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] TERMINAL_COUNT = 8'(TIMEOUT_CYCLES);

    state_t      state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q,  rsp_err_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        err_cnt_d  = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    // The command type is carried by the next state itself.
                    state_d = cmd_write ? ST_WRITE : ST_READ_REQ;
                end
            end

            ST_WRITE: begin
`ifdef MM_INITIATOR_WRITE_ACK_EN
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
`else
                state_d    = ST_IDLE;
`endif
            end

            ST_READ_REQ: begin
                wait_cnt_d = '0;
                state_d    = ST_READ_WAIT;
            end

            ST_READ_WAIT: begin
                // data_valid is checked first so that data arriving on the
                // terminal-count edge still completes as a success.
                if (data_valid) begin
                    rsp_data_d = rd_data;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (wait_cnt_q + 8'd1 == TERMINAL_COUNT) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d    = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Moore outputs: the request pulses are one cycle long because WRITE and
    // READ_REQ each last exactly one cycle, and they can never coincide.
    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rd_req    = (state_q == ST_READ_REQ);
    assign wr_req    = (state_q == ST_WRITE);
    assign rd_addr   = addr_q;
    assign wr_addr   = addr_q;
    assign wr_data   = wdata_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: doc/mm_initiator.md
MM_INITIATOR -- requirements
Module: mm_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8, SHALL set the maximum number of READ_WAIT cycles (legal 1..255) before a read is declared failed.
REQ-002 clk  input  1  single system clock; all state on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a posedge.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  target address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a posedge.
REQ-011 rsp_data  output  32  read data; 0 on error or write ack.
REQ-012 rsp_err  output  1  1 = read timed out.
REQ-013 rd_req / rd_addr  output  1 / 32  bus read request pulse and address.
REQ-014 rd_data / data_valid  input  32 / 1  bus read data and its qualifier from the responder.
REQ-015 wr_req / wr_addr / wr_data  output  1 / 32 / 32  bus write pulse, address, data.
REQ-016 err_count  output  8  saturating count of timed-out reads.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE, READ_REQ, READ_WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-018 On accept at edge N the block SHALL latch cmd_addr, cmd_wdata, cmd_write and go to WRITE or READ_REQ.
REQ-019 WRITE: wr_req SHALL be 1 for exactly the one cycle after accept, with wr_addr/wr_data = latched values.
REQ-020 READ_REQ: rd_req SHALL be 1 for exactly the one cycle after accept, with rd_addr = latched address; next state READ_WAIT, timeout counter cleared to 0.
REQ-021 READ_WAIT: on data_valid=1 the block SHALL capture rd_data into rsp_data, set rsp_err=0, go to RESP.
REQ-022 READ_WAIT without data_valid: counter SHALL increment; when it reaches TIMEOUT_CYCLES the block SHALL set rsp_data=0, rsp_err=1, increment err_count (saturate at 255), go to RESP.
REQ-023 data_valid on the same edge as the timeout terminal count SHALL win (success, no error).
REQ-024 data_valid outside READ_WAIT SHALL be ignored; rd_data SHALL not be captured.
REQ-025 RESP: rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready=1 at a posedge, then IDLE.
REQ-026 rd_req and wr_req SHALL never be 1 in the same cycle; each SHALL pulse at most once per command.
REQ-027 Minimum read latency: accept edge N, rd_req in cycle N+1, data_valid earliest sampled at edge N+2, rsp_valid from cycle N+3.
REQ-028 rd_addr, wr_addr, wr_data SHALL hold the last latched values between commands.

Reset
REQ-029 While reset=1: state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, rd_req=0, wr_req=0, all addresses/data=0, counter=0, err_count=0.
REQ-030 Reset mid-operation SHALL abandon any outstanding command with no response; a data_valid arriving after reset release SHALL be ignored.

Configuration
REQ-031 Macro MM_INITIATOR_WRITE_ACK_EN defined: after WRITE the FSM SHALL enter RESP with rsp_data=0, rsp_err=0.
REQ-032 Macro undefined: after WRITE the FSM SHALL return to IDLE (cmd_ready=1 the cycle after wr_req) and writes SHALL produce no response.

Verification
REQ-033 Read addr 0x0, responder returns 0x00000005 one cycle after rd_req -> single rd_req pulse, rsp_data=0x00000005, rsp_err=0, rsp_valid from accept+3.
REQ-034 Write addr 0x0 data 0x7 -> one wr_req cycle with wr_addr=0, wr_data=0x7; ack response only when MM_INITIATOR_WRITE_ACK_EN defined.
REQ-035 Read addr 0x40, no data_valid, TIMEOUT_CYCLES=8 -> rsp_err=1, rsp_data=0 after 8 wait cycles, err_count 0->1.
REQ-036 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0, new cmd_valid not accepted.
REQ-037 Reset asserted during READ_WAIT, data_valid pulsed after release -> no response, all outputs at reset values, IDLE.
REQ-038 256 consecutive timed-out reads -> err_count saturates at 255.
